// File: rtl/ahb_lite_req_sched.sv
// ahb_lite_req_sched: two-port round-robin front-end that issues
// single AHB-Lite transfers, one outstanding at a time.
module ahb_lite_req_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_write,
    input  logic [5:0]              req_size,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic [1:0]              HTRANS,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [2:0]              HBURST,
    output logic [3:0]              HPROT,
    output logic                    HMASTLOCK,
    output logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH-1:0]   HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    localparam logic [2:0] MAX_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_LERR
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [2:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  owner;
    } cmd_t;

    state_t state_q, state_d;
    cmd_t   cmd_q, sel;

    logic                  last_gnt;
    logic                  gnt_idx;
    logic                  accept;
    logic                  sel_bad;
    logic [ADDR_WIDTH-1:0] align_mask;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        gnt_idx = 1'b0;
        if (&req_valid) begin
            gnt_idx = ~last_gnt;
        end else begin
            gnt_idx = req_valid[1];
        end
    end

    always_comb begin
        sel.write = req_write[gnt_idx];
        sel.size  = gnt_idx ? req_size[5:3] : req_size[2:0];
        sel.addr  = gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : req_addr[ADDR_WIDTH-1:0];
        sel.wdata = gnt_idx ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : req_wdata[DATA_WIDTH-1:0];
        sel.owner = gnt_idx;
    end

    always_comb begin
        align_mask = ~({ADDR_WIDTH{1'b1}} << sel.size);
        sel_bad    = (sel.size > MAX_SIZE) || (|(sel.addr & align_mask));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        accept    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    accept             = 1'b1;
                    req_ready[gnt_idx] = 1'b1;
                    state_d            = sel_bad ? S_LERR : S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    state_d = S_IDLE;
                end
            end
            S_LERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cmd_q     <= '0;
            last_gnt  <= 1'b1;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (accept) begin
                cmd_q    <= sel;
                last_gnt <= gnt_idx;
            end
            if ((state_q == S_DATA) && HREADY) begin
                rsp_valid[cmd_q.owner] <= 1'b1;
                rsp_rdata <= cmd_q.write ? '0 : HRDATA;
                rsp_err   <= HRESP;
            end
            if (state_q == S_LERR) begin
                rsp_valid[cmd_q.owner] <= 1'b1;
                rsp_err <= 1'b1;
            end
        end
    end

    // Address-phase controls stay on the captured command between transfers.
    assign HADDR     = cmd_q.addr;
    assign HWRITE    = cmd_q.write;
    assign HSIZE     = cmd_q.size;
    assign HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign HWDATA    = ((state_q == S_DATA) && cmd_q.write) ? cmd_q.wdata : '0;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_req_sched.sv
// tb_ahb_lite_req_sched: directed and random transfers against a
// transaction-level expectation of grant order, timing and responses.
module tb_ahb_lite_req_sched;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [5:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_assert = 0;
    int n_fail   = 0;
    int last_gnt = 1;

    ahb_lite_req_sched #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_size (req_size),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HMASTLOCK(HMASTLOCK),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_htrans"}, 64'(HTRANS), 64'd0);
        chk({tag, "_haddr"}, 64'(HADDR), 64'd0);
        chk({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
        chk({tag, "_hsize"}, 64'(HSIZE), 64'd0);
        chk({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    // One command from requester r, starting at a negedge with the
    // FSM idle; returns at the cycle where the response is visible.
    task automatic txn(input int r, input bit wr, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int waits, input bit er,
                       input logic [31:0] rd);
        bit lerr;
        logic [1:0] own;
        lerr = (sz > 3'd2) || ((a % (32'd1 << sz)) != 32'd0);
        own = 2'(1 << r);
        req_valid[r] = 1'b1;
        req_write[r] = wr;
        req_size[3*r +: 3] = sz;
        req_addr[32*r +: 32] = a;
        req_wdata[32*r +: 32] = wd;
        HREADY = 1'b1;
        HRESP = 1'b0;
        #1;
        chk("accept_ready", 64'(req_ready), 64'(own));
        chk("accept_htrans", 64'(HTRANS), 64'd0);
        last_gnt = r;
        @(negedge HCLK);
        req_valid[r] = 1'b0;
        #1;
        chk("busy_ready", 64'(req_ready), 64'd0);
        if (lerr) begin
            chk("lerr_htrans", 64'(HTRANS), 64'd0);
            chk("lerr_quiet", 64'(rsp_valid), 64'd0);
            @(negedge HCLK);
            #1;
            chk("lerr_rsp_valid", 64'(rsp_valid), 64'(own));
            chk("lerr_rsp_err", 64'(rsp_err), 64'd1);
            chk("lerr_rsp_rdata", 64'(rsp_rdata), 64'd0);
            chk("lerr_htrans_end", 64'(HTRANS), 64'd0);
            return;
        end
        chk("addr_htrans", 64'(HTRANS), 64'h2);
        chk("addr_haddr", 64'(HADDR), 64'(a));
        chk("addr_hwrite", 64'(HWRITE), 64'(wr));
        chk("addr_hsize", 64'(HSIZE), 64'(sz));
        @(negedge HCLK);
        for (int i = 0; i < waits; i++) begin
            HREADY = 1'b0;
            HRESP = er && (i == waits - 1);
            HRDATA = $urandom;
            #1;
            chk("wait_htrans", 64'(HTRANS), 64'd0);
            chk("wait_haddr", 64'(HADDR), 64'(a));
            if (wr) chk("wait_hwdata", 64'(HWDATA), 64'(wd));
            chk("wait_no_rsp", 64'(rsp_valid), 64'd0);
            @(negedge HCLK);
        end
        HREADY = 1'b1;
        HRESP = er;
        HRDATA = rd;
        #1;
        chk("data_htrans", 64'(HTRANS), 64'd0);
        if (wr) chk("data_hwdata", 64'(HWDATA), 64'(wd));
        chk("data_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge HCLK);
        HRESP = 1'b0;
        HRDATA = $urandom;
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(own));
        chk("rsp_err", 64'(rsp_err), 64'(er));
        chk("rsp_rdata", 64'(rsp_rdata), wr ? 64'd0 : 64'(rd));
        chk("rsp_htrans", 64'(HTRANS), 64'd0);
    endtask

    initial begin
        int cnt[2];
        int g;
        int o;
        int r;
        bit wr;
        bit er;
        int w;
        logic [2:0] sz;
        logic [31:0] a;

        HRESETn = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_size = '0;
        req_addr = '0;
        req_wdata = '0;
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP = 1'b0;
        #2;
        HRESETn = 1'b0;
        repeat (2) @(negedge HCLK);
        #1;
        chk_reset_outputs("reset");
        chk("reset_hburst", 64'(HBURST), 64'd0);
        chk("reset_hprot", 64'(HPROT), 64'h3);
        chk("reset_hmastlock", 64'(HMASTLOCK), 64'd0);
        HRESETn = 1'b1;
        last_gnt = 1;
        @(negedge HCLK);

        txn(0, 1'b1, 3'd2, 32'h0000_0004, 32'hA5A5_5A5A, 0, 1'b0, 32'h0);

        cnt[0] = 4;
        cnt[1] = 4;
        while (cnt[0] + cnt[1] > 0) begin
            if (cnt[0] > 0 && cnt[1] > 0) g = 1 - last_gnt;
            else g = (cnt[0] > 0) ? 0 : 1;
            o = 1 - g;
            req_valid[o] = (cnt[o] > 0);
            req_write[o] = 1'b0;
            req_size[3*o +: 3] = 3'd2;
            req_addr[32*o +: 32] = 32'(32'h100 + o * 32'h40 + cnt[o] * 4);
            txn(g, 1'b0, 3'd2, 32'(32'h100 + g * 32'h40 + cnt[g] * 4),
                32'h0, 0, 1'b0, 32'(32'hD000_0000 + g * 256 + cnt[g]));
            cnt[g]--;
        end

        txn(1, 1'b0, 3'd2, 32'h0000_0010, 32'h0, 3, 1'b0, 32'h0000_00C3);
        txn(0, 1'b1, 3'd2, 32'h0000_0008, 32'h1234_5678, 1, 1'b1, 32'h0);
        txn(0, 1'b0, 3'd2, 32'h0000_0002, 32'h0, 0, 1'b0, 32'h0);
        txn(1, 1'b0, 3'd3, 32'h0000_0008, 32'h0, 0, 1'b0, 32'h0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            w = $urandom_range(0, 3);
            er = (w > 0) && ($urandom_range(0, 3) == 0);
            txn(r, wr, sz, a, $urandom, w, er, $urandom);
        end

        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_size[5:3] = 3'd2;
        req_addr[63:32] = 32'h0000_0020;
        HREADY = 1'b1;
        #1;
        chk("rst_accept", 64'(req_ready), 64'h2);
        @(negedge HCLK);
        req_valid[1] = 1'b0;
        #1;
        chk("rst_addr_phase", 64'(HTRANS), 64'h2);
        @(negedge HCLK);
        HREADY = 1'b0;
        #1;
        chk("rst_data_phase", 64'(HTRANS), 64'd0);
        #2;
        HRESETn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESETn = 1'b1;
        last_gnt = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            #1;
            chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
            chk("post_rst_htrans", 64'(HTRANS), 64'd0);
        end
        @(negedge HCLK);

        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_size[5:3] = 3'd2;
        req_addr[63:32] = 32'h0000_0044;
        txn(0, 1'b0, 3'd2, 32'h0000_0030, 32'h0, 0, 1'b0, 32'h5A5A_0001);
        txn(1, 1'b0, 3'd2, 32'h0000_0044, 32'h0, 0, 1'b0, 32'h5A5A_0002);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
